// File: rtl/conv_window_sequencer.sv
// Sliding-window sequencer: captures an IN_ROWS x IN_COLS tile and streams its K_ROWS x K_COLS
// windows, LANES per beat. Define CONV_WINDOW_PREFETCH_EN to accept the next tile on the last beat.
module conv_window_sequencer #(
    parameter int DW      = 8,
    parameter int IN_ROWS = 14,
    parameter int IN_COLS = 10,
    parameter int K_ROWS  = 11,
    parameter int K_COLS  = 7,
    parameter int STRIDE  = 1,
    parameter int LANES   = 4,
    localparam int STEP     = (STRIDE == 0) ? 1 : STRIDE,
    localparam int OUT_ROWS = (IN_ROWS - K_ROWS) / STEP + 1,
    localparam int OUT_COLS = (IN_COLS - K_COLS) / STEP + 1,
    localparam int NWIN     = OUT_ROWS * OUT_COLS,
    localparam int NBEAT    = (NWIN + LANES - 1) / LANES,
    localparam int KPIX     = K_ROWS * K_COLS,
    localparam int NPIX     = IN_ROWS * IN_COLS,
    localparam int WW       = KPIX * DW,
    localparam int TILE_W   = NPIX * DW,
    localparam int WINW     = $clog2(NWIN) + 1,
    localparam int BW       = $clog2(NBEAT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TILE_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*WW-1:0]   out_data,
    output logic [LANES-1:0]      out_mask,
    output logic [WINW-1:0]       out_win,
    output logic                  out_last
);

    generate
        if (IN_ROWS < K_ROWS || IN_COLS < K_COLS || STRIDE == 0) begin : g_bad_geometry
            $error("conv_window_sequencer: window larger than tile or zero stride");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [BW-1:0]      beat_r;
    logic [BW-1:0]      next_beat_s;
    logic [TILE_W-1:0]  tile_r;
    logic               load_s;
    logic               last_s;
    int                 beat_base_s;

    // Extract window n from a packed tile; windows past the end read as zero.
    function automatic logic [WW-1:0] window_at(input logic [TILE_W-1:0] tile, input int n);
        logic [WW-1:0] w;
        int r0;
        int c0;
        int idx;
        w = '0;
        if (n < NWIN) begin
            r0 = (n / OUT_COLS) * STEP;
            c0 = (n % OUT_COLS) * STEP;
            for (int i = 0; i < K_ROWS; i++) begin
                for (int j = 0; j < K_COLS; j++) begin
                    idx = (r0 + i) * IN_COLS + (c0 + j);
                    w[(KPIX - 1 - (i * K_COLS + j)) * DW +: DW] = tile[(NPIX - 1 - idx) * DW +: DW];
                end
            end
        end else begin
            w = '0;
        end
        return w;
    endfunction

    assign last_s      = (beat_r == BW'(NBEAT - 1));
    assign beat_base_s = int'(beat_r) * LANES;
    assign out_last    = last_s;
    assign out_win     = WINW'(beat_base_s);

    // Lane data and mask derived purely from the tile register and beat counter.
    always_comb begin
        out_data = '0;
        out_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            out_data[(LANES - 1 - l) * WW +: WW] = window_at(tile_r, beat_base_s + l);
            out_mask[l] = ((beat_base_s + l) < NWIN) ? 1'b1 : 1'b0;
        end
    end

    // Next-state, beat advance and handshake decode.
    always_comb begin
        next_state_s = state_r;
        next_beat_s  = beat_r;
        load_s       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_s       = 1'b1;
                    next_beat_s  = '0;
                    next_state_s = EMIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && last_s) begin
`ifdef CONV_WINDOW_PREFETCH_EN
                    in_ready    = 1'b1;
                    next_beat_s = '0;
                    if (in_valid) begin
                        load_s = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
`else
                    next_beat_s  = '0;
                    next_state_s = IDLE;
`endif
                end else if (out_ready) begin
                    next_beat_s = beat_r + BW'(1);
                end else begin
                    next_beat_s = beat_r;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_beat_s  = '0;
            end
        endcase
    end

    // State, beat counter and tile register; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            beat_r  <= '0;
            tile_r  <= '0;
        end else begin
            state_r <= next_state_s;
            beat_r  <= next_beat_s;
            if (load_s) begin
                tile_r <= in_data;
            end else begin
                tile_r <= tile_r;
            end
        end
    end

endmodule
